// File: rtl/act_pkg.sv
// Shared types and helpers for the per-pixel activation stage.
// act_apply works on a widened signed value so one function serves any lane width up to ACT_W_MAX.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_RELU   = 2'd0,
    ACT_LEAKY  = 2'd1,
    ACT_CLAMP  = 2'd2,
    ACT_BYPASS = 2'd3
  } act_mode_e;

  localparam int ACT_W_MAX = 64;

  function automatic int pix_per_frame(input int width, input int height);
    return width * height;
  endfunction

  // Sign-extended input in, sign-extended result out; callers keep the low lane bits.
  function automatic logic signed [ACT_W_MAX-1:0] act_apply(
    input logic signed [ACT_W_MAX-1:0] x,
    input act_mode_e                   mode,
    input logic signed [ACT_W_MAX-1:0] clip_max,
    input int unsigned                 shift
  );
    logic signed [ACT_W_MAX-1:0] y;
    y = x;
    case (mode)
      ACT_RELU:  y = (x > 0) ? x : '0;
      ACT_LEAKY: y = (x >= 0) ? x : (x >>> shift);
      ACT_CLAMP: begin
        if (x <= 0 || clip_max <= 0) y = '0;
        else if (x > clip_max)       y = clip_max;
        else                         y = x;
      end
      default:   y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/act_lane.sv
// Combinational single-lane activation: widens the lane, applies act_apply, narrows back.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_BITS  = 32,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [DATA_BITS-1:0] x_i,
  input  act_mode_e            mode_i,
  input  logic [DATA_BITS-1:0] clip_max_i,
  output logic [DATA_BITS-1:0] y_o
);

  logic signed [ACT_W_MAX-1:0] x_ext;
  logic signed [ACT_W_MAX-1:0] clip_ext;
  logic signed [ACT_W_MAX-1:0] y_ext;
  logic                        unused_y_hi;

  assign x_ext    = ACT_W_MAX'($signed(x_i));
  assign clip_ext = ACT_W_MAX'($signed(clip_max_i));
  assign y_ext    = act_apply(x_ext, mode_i, clip_ext, LEAK_SHIFT);
  // Upper bits are pure sign extension of an in-range result.
  assign y_o         = y_ext[DATA_BITS-1:0];
  assign unused_y_hi = ^y_ext;

endmodule

// File: rtl/relu_act_pipe.sv
// Per-pixel activation stage: CHANNELS parallel lanes, one output register stage,
// frame-position tagging (sof/eof) and a per-frame latched activation mode.
module relu_act_pipe
  import act_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 26,
  parameter int IMAGE_HEIGHT = 34,
  parameter int CHANNELS     = 32,
  parameter int DATA_BITS    = 32,
  parameter int LEAK_SHIFT   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    mode,
  input  logic [DATA_BITS-1:0]          clip_max,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*DATA_BITS-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*DATA_BITS-1:0] out_data,
  output logic                          out_sof,
  output logic                          out_eof,
  output logic                          frame_done
);

  localparam int PIX   = pix_per_frame(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int CNT_W = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX - 1);

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  act_mode_e                     mode_q, mode_d;
  logic [DATA_BITS-1:0]          clip_q, clip_d;
  logic                          valid_q, valid_d;
  logic [CHANNELS*DATA_BITS-1:0] data_q, data_d;
  logic                          sof_q, sof_d;
  logic                          eof_q, eof_d;
  logic                          done_q, done_d;

  logic                          accept;
  logic                          consume;
  logic                          first_pix;
  act_mode_e                     eff_mode;
  logic [DATA_BITS-1:0]          eff_clip;
  logic [CHANNELS*DATA_BITS-1:0] act_data;

  // Valid/ready: a beat moves when valid && ready on a rising edge. The output register
  // may take a new beat whenever it is empty or being drained in the same cycle, and
  // once out_valid is high it holds data/sof/eof until out_ready takes the beat.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && out_ready;

  // Pixel 0 uses the live mode/clip so the frame's first beat already sees the new setting.
  assign first_pix = (cnt_q == '0);
  assign eff_mode  = first_pix ? act_mode_e'(mode) : mode_q;
  assign eff_clip  = first_pix ? clip_max : clip_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    act_lane #(
      .DATA_BITS (DATA_BITS),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .x_i       (in_data[k*DATA_BITS +: DATA_BITS]),
      .mode_i    (eff_mode),
      .clip_max_i(eff_clip),
      .y_o       (act_data[k*DATA_BITS +: DATA_BITS])
    );
  end

  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    clip_d  = clip_q;
    valid_d = valid_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    done_d  = consume && eof_q;
    if (consume) valid_d = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = act_data;
      sof_d   = first_pix;
      eof_d   = (cnt_q == LAST_PIX);
      cnt_d   = (cnt_q == LAST_PIX) ? '0 : cnt_q + CNT_W'(1);
      if (first_pix) begin
        mode_d = eff_mode;
        clip_d = clip_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mode_q  <= ACT_RELU;
      clip_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      clip_q  <= clip_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      done_q  <= done_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_sof    = sof_q;
  assign out_eof    = eof_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_relu_act_pipe.sv
// Bench for relu_act_pipe: constant vector table, scoreboard against a frame-level
// reference model, and directed stall / mode-switch / mid-frame reset sequences.
`timescale 1ns/1ps
module tb_relu_act_pipe;

  localparam int W   = 26;
  localparam int H   = 34;
  localparam int CH  = 32;
  localparam int DW  = 32;
  localparam int LS  = 3;
  localparam int PIX = W * H;
  localparam int BW  = CH * DW;
  localparam int QW  = BW + 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] clip_max = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic          out_sof;
  logic          out_eof;
  logic          frame_done;

  always #5 clk = ~clk;

  relu_act_pipe #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .CHANNELS    (CH),
    .DATA_BITS   (DW),
    .LEAK_SHIFT  (LS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .clip_max  (clip_max),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .frame_done(frame_done)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_beat(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int k = CH - 1; k >= 0; k--)
      if (got[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL %s lane %0d: got 0x%0h expected 0x%0h at %0t",
               name, bad, got[bad*DW +: DW], exp[bad*DW +: DW], $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_act(input longint x, input int m, input longint clip);
    longint r;
    longint d;
    d = longint'(1) << LS;
    case (m)
      0: r = (x > 0) ? x : 0;
      1: begin
        if (x >= 0) r = x;
        else begin
          r = x / d;                      // truncates toward zero
          if (r * d != x) r = r - 1;      // floor for negative values
        end
      end
      2: begin
        if (x <= 0 || clip <= 0) r = 0;
        else if (x > clip)       r = clip;
        else                     r = x;
      end
      default: r = x;
    endcase
    return r[DW-1:0];
  endfunction

  function automatic logic [BW-1:0] ref_beat(input logic [BW-1:0] d, input int m, input longint clip);
    logic [BW-1:0] r;
    logic [DW-1:0] lane;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      lane = d[k*DW +: DW];
      r[k*DW +: DW] = ref_act(longint'($signed(lane)), m, clip);
    end
    return r;
  endfunction

  // Scoreboard entry: {sof, eof, data}
  logic [QW-1:0] exp_q[$];
  int     mdl_cnt   = 0;
  int     mdl_mode  = 0;
  longint mdl_clip  = 0;
  bit     exp_done  = 1'b0;
  int     n_acc     = 0;
  int     sof_seen  = 0;
  int     eof_seen  = 0;
  int     done_seen = 0;

  task automatic clear_model();
    exp_q.delete();
    mdl_cnt  = 0;
    mdl_mode = 0;
    mdl_clip = 0;
    exp_done = 1'b0;
  endtask

  // Sampled mid-cycle: inputs are driven at negedge, handshakes resolve at the next posedge.
  always begin : monitor
    bit            exp_valid;
    bit            exp_rdy;
    bit            fire_eof;
    logic [QW-1:0] head;
    @(negedge clk);
    #1;
    if (rst_n) begin
      chk("frame_done", frame_done, exp_done);
      if (frame_done) done_seen++;
      exp_valid = (exp_q.size() != 0);
      exp_rdy   = !exp_valid || out_ready;
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, exp_rdy);
      if (out_valid && out_ready && out_sof) sof_seen++;
      if (out_valid && out_ready && out_eof) eof_seen++;
      fire_eof = 1'b0;
      if (exp_valid) begin
        head = exp_q[0];
        chk_beat("out_data", out_data, head[BW-1:0]);
        chk("out_sof", out_sof, head[BW+1]);
        chk("out_eof", out_eof, head[BW]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          fire_eof = head[BW];
        end
      end
      if (in_valid && exp_rdy) begin
        if (mdl_cnt == 0) begin
          mdl_mode = int'(mode);
          mdl_clip = longint'($signed(clip_max));
        end
        exp_q.push_back({(mdl_cnt == 0), (mdl_cnt == PIX - 1),
                         ref_beat(in_data, mdl_mode, mdl_clip)});
        mdl_cnt = (mdl_cnt == PIX - 1) ? 0 : mdl_cnt + 1;
        n_acc++;
      end
      exp_done = fire_eof;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [BW-1:0] rand_data();
    logic [BW-1:0] d;
    logic [DW-1:0] lane;
    logic [DW-1:0] edges[4];
    edges[0] = 32'h8000_0000;
    edges[1] = 32'h7FFF_FFFF;
    edges[2] = 32'h0000_0000;
    edges[3] = 32'hFFFF_FFFF;
    for (int k = 0; k < CH; k++) begin
      case ($urandom_range(0, 3))
        0:       lane = DW'($urandom_range(0, 40)) - DW'(20);
        1:       lane = edges[$urandom_range(0, 3)];
        default: lane = $urandom;
      endcase
      d[k*DW +: DW] = lane;
    end
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  // Drives until n more beats have been accepted; the last one lands on the following posedge.
  task automatic run_beats(input int n, input int vld_pct, input int rdy_pct);
    int target;
    int budget;
    target = n_acc + n;
    budget = n * 20 + 100;
    while (n_acc < target) begin
      @(negedge clk);
      in_valid  = ($urandom_range(1, 100) <= vld_pct);
      out_ready = ($urandom_range(1, 100) <= rdy_pct);
      in_data   = rand_data();
      #2;
      budget--;
      if (budget == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL run_beats_timeout: accepted %0d required %0d", n_acc, target);
        break;
      end
    end
  endtask

  // ---------------- constant vector table ----------------
  typedef struct {
    logic [1:0]    m;
    logic [DW-1:0] clip;
    logic [DW-1:0] vi[4];
    logic [DW-1:0] vo[4];
  } vec_t;

  vec_t tbl[6];

  task automatic set_vec(input int i, input logic [1:0] m, input logic [DW-1:0] c,
                         input logic [DW-1:0] i0, input logic [DW-1:0] i1,
                         input logic [DW-1:0] i2, input logic [DW-1:0] i3,
                         input logic [DW-1:0] o0, input logic [DW-1:0] o1,
                         input logic [DW-1:0] o2, input logic [DW-1:0] o3);
    tbl[i].m     = m;
    tbl[i].clip  = c;
    tbl[i].vi[0] = i0; tbl[i].vi[1] = i1; tbl[i].vi[2] = i2; tbl[i].vi[3] = i3;
    tbl[i].vo[0] = o0; tbl[i].vo[1] = o1; tbl[i].vo[2] = o2; tbl[i].vo[3] = o3;
  endtask

  // ---------------- main sequence ----------------
  logic [BW-1:0] held;

  initial begin : main
    set_vec(0, 2'd0, 32'd0, 32'd5, -32'sd7, 32'd0, 32'h7FFF_FFFF,
                            32'd5, 32'd0, 32'd0, 32'h7FFF_FFFF);
    set_vec(1, 2'd1, 32'd0, -32'sd64, -32'sd1, 32'd16, 32'd0,
                            -32'sd8, -32'sd1, 32'd16, 32'd0);
    set_vec(2, 2'd2, 32'd6, 32'd3, 32'd9, -32'sd2, 32'd0,
                            32'd3, 32'd6, 32'd0, 32'd0);
    set_vec(3, 2'd2, -32'sd4, 32'd5, 32'd1, -32'sd3, 32'd100,
                              32'd0, 32'd0, 32'd0, 32'd0);
    set_vec(4, 2'd3, 32'd0, -32'sd5, 32'h8000_0000, 32'd7, -32'sd1,
                            -32'sd5, 32'h8000_0000, 32'd7, -32'sd1);
    set_vec(5, 2'd1, 32'd0, 32'h8000_0000, -32'sd7, 32'h7FFF_FFFF, -32'sd8,
                            32'hF000_0000, -32'sd1, 32'h7FFF_FFFF, -32'sd1);

    // Reset state
    #1 rst_n = 1'b0;
    #5;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data[63:0], 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: each applied as pixel 0 of a fresh frame so its mode is taken
    for (int i = 0; i < 6; i++) begin
      do_reset();
      @(negedge clk);
      mode      = tbl[i].m;
      clip_max  = tbl[i].clip;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = '0;
      for (int k = 0; k < 4; k++) in_data[k*DW +: DW] = tbl[i].vi[k];
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_sof", i), out_sof, 1);
      for (int k = 0; k < 4; k++)
        chk($sformatf("tbl%0d_lane%0d", i, k), out_data[k*DW +: DW], tbl[i].vo[k]);
    end

    // Frame A: ReLU back to back, mode input flips to bypass at pixel 100 (ignored)
    do_reset();
    sof_seen  = 0;
    eof_seen  = 0;
    done_seen = 0;
    mode      = 2'd0;
    clip_max  = DW'($urandom_range(1, 30));
    run_beats(100, 100, 100);
    mode = 2'd3;
    run_beats(PIX - 100, 100, 100);

    // Frame B: bypass from pixel 0, random flow, then a long stall with data offered
    run_beats(200, 80, 70);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = rand_data();
    #2;
    @(negedge clk);
    in_data = rand_data();
    #2;
    held = out_data;
    chk("hold_valid", out_valid, 1);
    repeat (4) begin
      @(negedge clk);
      in_data = rand_data();
      #2;
      chk("hold_in_ready", in_ready, 0);
      chk_beat("hold_stable", out_data, held);
    end
    if (mdl_cnt != 0) run_beats(PIX - mdl_cnt, 100, 100);
    idle(4);
    chk("frames_sof_count", sof_seen, 2);
    chk("frames_eof_count", eof_seen, 2);
    chk("frames_done_count", done_seen, 2);

    // Frame C: leaky, interrupted by reset at pixel 300
    mode     = 2'd1;
    clip_max = DW'($urandom_range(1, 30));
    run_beats(300, 100, 100);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = rand_data();
    #3;
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data[63:0], 0);
    chk("midrst_out_sof", out_sof, 0);
    chk("midrst_out_eof", out_eof, 0);
    chk("midrst_frame_done", frame_done, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    mode     = 2'd2;
    clip_max = DW'($urandom_range(0, 30)) - DW'(5);
    in_valid = 1'b1;
    in_data  = rand_data();
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("post_reset_valid", out_valid, 1);
    chk("post_reset_sof", out_sof, 1);
    run_beats(60, 70, 70);
    idle(4);
    #2;
    chk("drain_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
